// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- central pipeline sequencer for the 5-stage 16-bit core.
//
// Drives the enable/flush pair for the PC and every pipeline register
// (IF/ID, ID/EX, EX/MEM, MEM/WB). It handles four events: memory-wait
// freeze, taken-branch squash, load-use stall, and HLT drain/halt/resume.
// A saturating counter records stall cycles for performance debug.
//
// Parameters
//   DRAIN_CYC  cycles spent in DRAIN after HLT leaves ID (must be >= 1)
//   CNT_W      width of stall_cnt
//
// Ports
//   clk              clock, all state updates on the rising edge
//   reset            synchronous, active-high
//   mem_busy         data memory not ready this cycle
//   branch_taken_ex  branch in EX resolved taken
//   memread_ex       instruction in EX is a load
//   regwrite_ex      instruction in EX writes a register
//   regwrite_adr_ex  destination register of the EX instruction
//   rs_id, rt_id     source registers of the ID instruction
//   rs_used_id       ID instruction reads rs
//   rt_used_id       ID instruction reads rt
//   halt_id          ID instruction is HLT
//   resume           restart request while halted (pulse)
//   cnt_clear        clear stall_cnt
//   en_*             stage enables (combinational)
//   flush_*          synchronous bubble insert (combinational)
//   pc_sel_br        PC loads the branch target this cycle (combinational)
//   halted           core halted (registered)
//   stall_cnt        saturating count of en_pc=0 cycles outside HALTED
module pipe_ctrl #(
   parameter int unsigned DRAIN_CYC = 3,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mem_busy,
   input  logic             branch_taken_ex,
   input  logic             memread_ex,
   input  logic             regwrite_ex,
   input  logic [2:0]       regwrite_adr_ex,
   input  logic [2:0]       rs_id,
   input  logic [2:0]       rt_id,
   input  logic             rs_used_id,
   input  logic             rt_used_id,
   input  logic             halt_id,
   input  logic             resume,
   input  logic             cnt_clear,
   output logic             en_pc,
   output logic             en_ifid,
   output logic             en_idex,
   output logic             en_exmem,
   output logic             en_memwb,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             flush_exmem,
   output logic             flush_memwb,
   output logic             pc_sel_br,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int unsigned DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [DCW-1:0]   DRAIN_LOAD = DCW'(DRAIN_CYC - 1);
   localparam logic [DCW-1:0]   DRAIN_ONE  = DCW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t         state, state_nx;
   logic [DCW-1:0] drain_cnt, drain_cnt_nx;
   logic           halted_nx;
   logic           load_use;
   logic           hit_rs, hit_rt;

   // Hazard against a load still in EX: ID must wait one cycle for the data.
   assign hit_rs   = rs_used_id & (rs_id == regwrite_adr_ex);
   assign hit_rt   = rt_used_id & (rt_id == regwrite_adr_ex);
   assign load_use = memread_ex & regwrite_ex & (hit_rs | hit_rt);

   always_comb begin
      en_pc        = 1'b0;
      en_ifid      = 1'b0;
      en_idex      = 1'b0;
      en_exmem     = 1'b0;
      en_memwb     = 1'b0;
      flush_ifid   = 1'b0;
      flush_idex   = 1'b0;
      flush_exmem  = 1'b0;
      flush_memwb  = 1'b0;
      pc_sel_br    = 1'b0;
      state_nx     = state;
      drain_cnt_nx = drain_cnt;
      halted_nx    = halted;

      if (!reset) begin
         unique case (state)
            RUN: begin
               en_pc    = 1'b1;
               en_ifid  = 1'b1;
               en_idex  = 1'b1;
               en_exmem = 1'b1;
               en_memwb = 1'b1;
               if (mem_busy) begin
                  // Full freeze: nothing moves, nothing is flushed.
                  en_pc    = 1'b0;
                  en_ifid  = 1'b0;
                  en_idex  = 1'b0;
                  en_exmem = 1'b0;
                  en_memwb = 1'b0;
               end else if (branch_taken_ex) begin
                  // Squashes IF and ID, which also discards any load-use or
                  // HLT currently sitting in ID.
                  flush_ifid = 1'b1;
                  flush_idex = 1'b1;
                  pc_sel_br  = 1'b1;
               end else if (load_use) begin
                  en_pc      = 1'b0;
                  en_ifid    = 1'b0;
                  flush_idex = 1'b1;
               end else if (halt_id) begin
                  en_pc        = 1'b0;
                  en_ifid      = 1'b0;
                  flush_idex   = 1'b1;
                  state_nx     = DRAIN;
                  drain_cnt_nx = DRAIN_LOAD;
               end
            end

            DRAIN: begin
               if (!mem_busy) begin
                  // Front end held, bubbles fed into ID/EX while the older
                  // instructions retire.
                  en_idex    = 1'b1;
                  en_exmem   = 1'b1;
                  en_memwb   = 1'b1;
                  flush_idex = 1'b1;
                  if (drain_cnt == '0) begin
                     state_nx  = HALTED;
                     halted_nx = 1'b1;
                  end else begin
                     drain_cnt_nx = drain_cnt - DRAIN_ONE;
                  end
               end
            end

            HALTED: begin
               if (resume) begin
                  // PC already points past HLT; drop the stale IF/ID contents.
                  en_pc      = 1'b1;
                  flush_ifid = 1'b1;
                  halted_nx  = 1'b0;
                  state_nx   = RUN;
               end
            end

            default: begin
               state_nx = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         drain_cnt <= '0;
         halted    <= 1'b0;
         stall_cnt <= '0;
      end else begin
         state     <= state_nx;
         drain_cnt <= drain_cnt_nx;
         halted    <= halted_nx;
         if (cnt_clear) begin
            stall_cnt <= '0;
         end else if (!en_pc && (state != HALTED) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end
      end
   end

endmodule
